// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: block-mode sequencer (ECB/CBC/CTR/CFB/PCBC) wrapped around a single-block AES core
module aes_mode_ctrl #(
    parameter int BLK_S   = 128,
    parameter int IV_BITS = 128,
    parameter int BYTE_S  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_mode,
    input  logic               cfg_encrypt,
    input  logic [IV_BITS-1:0] cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_S-1:0]   in_blk,
    input  logic               in_last,
    output logic               aes_start,
    output logic               aes_encrypt,
    output logic [BLK_S-1:0]   aes_blk,
    input  logic               aes_done,
    input  logic [BLK_S-1:0]   aes_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_S-1:0]   out_blk,
    output logic               out_last,
    output logic               busy,
    output logic               err_mode
);
    typedef enum logic [2:0] {IDLE, WAIT_IN, START, CORE, OUT} state_t;
    localparam logic [2:0] M_ECB = 3'd0, M_CBC = 3'd1, M_CTR = 3'd2, M_CFB = 3'd3, M_PCBC = 3'd4;

    // Big-endian counter increment: the carry ripples upward one byte at a time.
    function automatic logic [IV_BITS-1:0] ctr_inc(input logic [IV_BITS-1:0] v);
        logic [IV_BITS-1:0] r;
        logic [BYTE_S:0]    s;
        logic               c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < IV_BITS / BYTE_S; i++) begin
            s = {1'b0, v[i*BYTE_S +: BYTE_S]} + {{BYTE_S{1'b0}}, c};
            r[i*BYTE_S +: BYTE_S] = s[BYTE_S-1:0];
            c = s[BYTE_S];
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic               enc_q, enc_d;
    logic [IV_BITS-1:0] iv_q, iv_d;
    logic [BLK_S-1:0]   p_q, p_d;
    logic               last_q, last_d;
    logic               aes_enc_q, aes_enc_d;
    logic [BLK_S-1:0]   aes_blk_q, aes_blk_d;
    logic [BLK_S-1:0]   out_blk_q, out_blk_d;
    logic               out_last_q, out_last_d;
    logic               err_q, err_d;
    logic               cfg_ready_q, in_ready_q, start_q, out_valid_q, busy_q;
    logic               chain, keystream;
    logic [BLK_S-1:0]   res_out;
    logic [IV_BITS-1:0] res_iv;

    // Next-state, datapath pre/post-processing and IV chaining.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        enc_d      = enc_q;
        iv_d       = iv_q;
        p_d        = p_q;
        last_d     = last_q;
        aes_enc_d  = aes_enc_q;
        aes_blk_d  = aes_blk_q;
        out_blk_d  = out_blk_q;
        out_last_d = out_last_q;
        err_d      = err_q;
        chain      = (mode_q == M_CBC) || (mode_q == M_PCBC);
        keystream  = (mode_q == M_CTR) || (mode_q == M_CFB);
        res_out    = keystream ? aes_result ^ p_q : (chain && !enc_q) ? aes_result ^ iv_q : aes_result;
        res_iv     = (mode_q == M_CBC)  ? (enc_q ? aes_result : p_q) :
                     (mode_q == M_CTR)  ? ctr_inc(iv_q) :
                     (mode_q == M_CFB)  ? (enc_q ? res_out : p_q) :
                     (mode_q == M_PCBC) ? p_q ^ res_out : iv_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    if (cfg_mode > M_PCBC) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d    = cfg_mode;
                        enc_d     = cfg_encrypt;
                        iv_d      = cfg_iv;
                        aes_enc_d = cfg_encrypt || (cfg_mode == M_CTR) || (cfg_mode == M_CFB);
                        state_d   = WAIT_IN;
                    end
                end
            end
            WAIT_IN: begin
                if (in_valid && in_ready_q) begin
                    p_d       = in_blk;
                    last_d    = in_last;
                    aes_blk_d = keystream ? iv_q : (chain && enc_q) ? in_blk ^ iv_q : in_blk;
                    state_d   = START;
                end
            end
            START: state_d = CORE;
            CORE: begin
                if (aes_done) begin
                    out_blk_d  = res_out;
                    out_last_d = last_q;
                    iv_d       = res_iv;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = out_last_q ? IDLE : WAIT_IN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and handshake flops; handshake outputs are decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            enc_q       <= 1'b0;
            iv_q        <= '0;
            p_q         <= '0;
            last_q      <= 1'b0;
            aes_enc_q   <= 1'b0;
            aes_blk_q   <= '0;
            out_blk_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            enc_q       <= enc_d;
            iv_q        <= iv_d;
            p_q         <= p_d;
            last_q      <= last_d;
            aes_enc_q   <= aes_enc_d;
            aes_blk_q   <= aes_blk_d;
            out_blk_q   <= out_blk_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            cfg_ready_q <= state_d == IDLE;
            in_ready_q  <= state_d == WAIT_IN;
            start_q     <= state_d == START;
            out_valid_q <= state_d == OUT;
            busy_q      <= state_d != IDLE;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign in_ready    = in_ready_q;
    assign aes_start   = start_q;
    assign aes_encrypt = aes_enc_q;
    assign aes_blk     = aes_blk_q;
    assign out_valid   = out_valid_q;
    assign out_blk     = out_blk_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign err_mode    = err_q;
endmodule
